// File: rtl/pwm_uart_ctrl_pkg.sv
// rtl/pwm_uart_ctrl_pkg.sv - shared types and control-word field positions for the PWM UART control stage
package pwm_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   // Control byte layout: {enable, breathe, duty[5:0]}
   localparam int ENABLE_BIT  = 7;
   localparam int BREATHE_BIT = 6;
   localparam int DUTY_MSB    = 5;
   localparam int DUTY_LSB    = 0;

   // Reference width of the PWM core fed by duty_out
   localparam int DUTY_W = 6;

endpackage

// File: rtl/pwm_uart_ctrl_if.sv
// rtl/pwm_uart_ctrl_if.sv - UART line in, PWM control word and status out
interface pwm_uart_ctrl_if;
   import pwm_ctrl_pkg::*;

   logic              rx_in;
   logic [DUTY_W-1:0] duty_out;
   logic              enable_out;
   logic              breathe_out;
   logic              ctrl_valid;
   logic              frame_err;
   logic              busy;

   // Decoder side: samples the line, drives the control word
   modport master (
      input  rx_in,
      output duty_out, enable_out, breathe_out, ctrl_valid, frame_err, busy
   );

   // Line driver / PWM core side
   modport slave (
      output rx_in,
      input  duty_out, enable_out, breathe_out, ctrl_valid, frame_err, busy
   );

endinterface

// File: rtl/pwm_uart_ctrl_sync.sv
// rtl/pwm_uart_ctrl_sync.sv - two-flop synchronizer for asynchronous single-bit inputs
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops; the first may go metastable, the second settles it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pwm_uart_ctrl.sv
// rtl/pwm_uart_ctrl.sv - 8N1 UART receiver that decodes each byte into the PWM control word
module pwm_uart_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1042,
   parameter int CNT_W        = 11
) (
   input  logic            clk,
   input  logic            rst_n,
   pwm_uart_ctrl_if.master bus
);

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [2:0]        bit_idx, bit_idx_nxt;
   logic [7:0]        shreg, shreg_nxt;
   logic [DUTY_W-1:0] duty_q, duty_nxt;
   logic              enable_q, enable_nxt;
   logic              breathe_q, breathe_nxt;
   logic              ctrl_valid_q, ctrl_valid_nxt;
   logic              frame_err_q, frame_err_nxt;
   logic              rx_s;

   sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.rx_in),
      .q     (rx_s)
   );

   // State, timing counter, shift register and the held control word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         shreg        <= '0;
         duty_q       <= '0;
         enable_q     <= 1'b0;
         breathe_q    <= 1'b0;
         ctrl_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         bit_idx      <= bit_idx_nxt;
         shreg        <= shreg_nxt;
         duty_q       <= duty_nxt;
         enable_q     <= enable_nxt;
         breathe_q    <= breathe_nxt;
         ctrl_valid_q <= ctrl_valid_nxt;
         frame_err_q  <= frame_err_nxt;
      end
   end

   // Frame sequencing; the control word is only touched on a good stop bit
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt + CNT_W'(1);
      bit_idx_nxt    = bit_idx;
      shreg_nxt      = shreg;
      duty_nxt       = duty_q;
      enable_nxt     = enable_q;
      breathe_nxt    = breathe_q;
      ctrl_valid_nxt = 1'b0;
      frame_err_nxt  = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!rx_s) state_nxt = START;
         end
         START: begin
            // Mid-start-bit check rejects glitches shorter than half a bit
            if (cnt == HALF_M1) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt   = DATA;
                  bit_idx_nxt = '0;
               end
            end
         end
         DATA: begin
            if (cnt == BIT_M1) begin
               cnt_nxt   = '0;
               shreg_nxt = {rx_s, shreg[7:1]};
               if (bit_idx == 3'd7) state_nxt = STOP;
               else                 bit_idx_nxt = bit_idx + 3'd1;
            end
         end
         STOP: begin
            // Returning to IDLE mid-stop-bit lets a back-to-back start edge be caught
            if (cnt == BIT_M1) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  enable_nxt     = shreg[ENABLE_BIT];
                  breathe_nxt    = shreg[BREATHE_BIT];
                  duty_nxt       = shreg[DUTY_MSB:DUTY_LSB];
                  ctrl_valid_nxt = 1'b1;
                  state_nxt      = IDLE;
               end else begin
                  frame_err_nxt = 1'b1;
                  state_nxt     = BREAK;
               end
            end
         end
         BREAK: begin
            // A held-low line must go idle before a new start is accepted
            cnt_nxt = '0;
            if (rx_s) state_nxt = IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.duty_out    = duty_q;
   assign bus.enable_out  = enable_q;
   assign bus.breathe_out = breathe_q;
   assign bus.ctrl_valid  = ctrl_valid_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_pwm_uart_ctrl.sv
// tb/tb_pwm_uart_ctrl.sv - self-checking bench for pwm_uart_ctrl
`timescale 1ns/1ps
module tb_pwm_uart_ctrl;
   import pwm_ctrl_pkg::*;

   localparam int CPB = 16;

   logic clk;
   logic rst_n;

   pwm_uart_ctrl_if bus ();

   pwm_uart_ctrl #(.CLKS_PER_BIT(CPB), .CNT_W(11)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0] data;
      logic       en;
      logic       br;
      logic [5:0] duty;
   } vec_t;

   vec_t       vecs[8];
   int         total = 0;
   int         passed = 0;
   logic [7:0] pulses[$];
   int         fe_cycles = 0;
   int         both_high = 0;

   // Record every control update and error pulse, sampled away from the active edge
   always @(negedge clk) begin
      if (bus.ctrl_valid) pulses.push_back({bus.enable_out, bus.breathe_out, bus.duty_out});
      if (bus.frame_err) fe_cycles++;
      if (bus.ctrl_valid && bus.frame_err) both_high++;
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // len_x100 is the bit period in hundredths of a clock, so skew accumulates realistically
   task automatic send_byte(input logic [7:0] b, input logic stop_val, input int len_x100, input int gap);
      logic [9:0] frame;
      int prev;
      int end_c;
      frame = {stop_val, b, 1'b0};
      prev = 0;
      for (int i = 0; i < 10; i++) begin
         bus.rx_in = frame[i];
         end_c = ((i + 1) * len_x100) / 100;
         wait_cycles(end_c - prev);
         prev = end_c;
      end
      if (gap > 0) begin
         bus.rx_in = 1'b1;
         wait_cycles(gap);
      end
   endtask

   task automatic check_word(input string name, input logic en, input logic br, input logic [5:0] duty);
      check({name, "_pulses"}, pulses.size(), 1);
      check({name, "_enable"}, int'(bus.enable_out), int'(en));
      check({name, "_breathe"}, int'(bus.breathe_out), int'(br));
      check({name, "_duty"}, int'(bus.duty_out), int'(duty));
      pulses.delete();
   endtask

   initial begin
      int busy_seen;
      logic [7:0] b;
      int len;

      vecs[0] = '{8'hA5, 1'b1, 1'b0, 6'd37};
      vecs[1] = '{8'hFF, 1'b1, 1'b1, 6'd63};
      vecs[2] = '{8'h00, 1'b0, 1'b0, 6'd0};
      vecs[3] = '{8'h81, 1'b1, 1'b0, 6'd1};
      vecs[4] = '{8'hC0, 1'b1, 1'b1, 6'd0};
      vecs[5] = '{8'h7F, 1'b0, 1'b1, 6'd63};
      vecs[6] = '{8'h2A, 1'b0, 1'b0, 6'd42};
      vecs[7] = '{8'hA5, 1'b1, 1'b0, 6'd37};

      bus.rx_in = 1'b1;
      rst_n = 1'b0;
      wait_cycles(4);
      check("rst_enable", int'(bus.enable_out), 0);
      check("rst_breathe", int'(bus.breathe_out), 0);
      check("rst_duty", int'(bus.duty_out), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_ctrl_valid", int'(bus.ctrl_valid), 0);
      check("rst_frame_err", int'(bus.frame_err), 0);
      rst_n = 1'b1;
      wait_cycles(5);

      // Table of single bytes, each followed by a short idle gap
      for (int i = 0; i < 8; i++) begin
         send_byte(vecs[i].data, 1'b1, CPB * 100, 4);
         check_word($sformatf("vec%0d", i), vecs[i].en, vecs[i].br, vecs[i].duty);
         check($sformatf("vec%0d_busy", i), int'(bus.busy), 0);
      end
      check("table_frame_err", fe_cycles, 0);

      // Back-to-back frames with no idle between stop and next start
      send_byte(8'hFF, 1'b1, CPB * 100, 0);
      check_word("b2b_ff", 1'b1, 1'b1, 6'd63);
      send_byte(8'h00, 1'b1, CPB * 100, 4);
      check_word("b2b_00", 1'b0, 1'b0, 6'd0);

      // Short low glitch after a good byte
      send_byte(8'hA5, 1'b1, CPB * 100, 4);
      check_word("pre_glitch", 1'b1, 1'b0, 6'd37);
      busy_seen = 0;
      bus.rx_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.busy) busy_seen = 1;
      end
      bus.rx_in = 1'b1;
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         if (bus.busy) busy_seen = 1;
      end
      check("glitch_busy_seen", busy_seen, 1);
      check("glitch_busy_end", int'(bus.busy), 0);
      check("glitch_pulses", pulses.size(), 0);
      check("glitch_enable", int'(bus.enable_out), 1);
      check("glitch_breathe", int'(bus.breathe_out), 0);
      check("glitch_duty", int'(bus.duty_out), 37);

      // Bad stop bit, line held low, then released
      send_byte(8'h3C, 1'b0, CPB * 100, 0);
      wait_cycles(40);
      check("brk_busy_low_line", int'(bus.busy), 1);
      bus.rx_in = 1'b1;
      wait_cycles(20);
      check("ferr_cycles", fe_cycles, 1);
      check("ferr_pulses", pulses.size(), 0);
      check("ferr_busy", int'(bus.busy), 0);
      check("ferr_enable", int'(bus.enable_out), 1);
      check("ferr_breathe", int'(bus.breathe_out), 0);
      check("ferr_duty", int'(bus.duty_out), 37);
      send_byte(8'h81, 1'b1, CPB * 100, 4);
      check_word("post_ferr", 1'b1, 1'b0, 6'd1);

      // Reset during data bit 4 of 0xC0
      send_byte(8'hFF, 1'b1, CPB * 100, 4);
      check_word("pre_rst", 1'b1, 1'b1, 6'd63);
      bus.rx_in = 1'b0;
      wait_cycles(CPB);
      for (int i = 0; i < 4; i++) begin
         bus.rx_in = 1'b0;
         wait_cycles(CPB);
      end
      wait_cycles(CPB / 2);
      check("mid_busy", int'(bus.busy), 1);
      rst_n = 1'b0;
      #1;
      check("midrst_enable", int'(bus.enable_out), 0);
      check("midrst_breathe", int'(bus.breathe_out), 0);
      check("midrst_duty", int'(bus.duty_out), 0);
      check("midrst_busy", int'(bus.busy), 0);
      bus.rx_in = 1'b1;
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(20);
      check("midrst_pulses", pulses.size(), 0);
      send_byte(8'hC0, 1'b1, CPB * 100, 4);
      check_word("post_rst", 1'b1, 1'b1, 6'd0);

      // Random bytes with up to +/-3% baud skew
      for (int i = 0; i < 200; i++) begin
         b = 8'($urandom_range(0, 255));
         len = CPB * 100 + $urandom_range(0, 96) - 48;
         send_byte(b, 1'b1, len, 4);
         check($sformatf("rand%0d_pulses", i), pulses.size(), 1);
         if (pulses.size() > 0) check($sformatf("rand%0d_word", i), int'(pulses[0]), int'(b));
         else check($sformatf("rand%0d_word", i), -1, int'(b));
         pulses.delete();
      end

      check("never_both_high", both_high, 0);
      check("final_ferr_cycles", fe_cycles, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
